// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit paths.
package uart_pkg;
    localparam int OVS     = 16;
    localparam int SMP_A   = 7;
    localparam int SMP_B   = 8;
    localparam int SMP_C   = 9;
    localparam int SMP_END = 15;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } rx_hold_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// Received-byte hand-off between the UART receiver and its consumer.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_fe;
    logic       rx_pe;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, rx_fe, rx_pe, rx_valid, input rx_ready);
    modport slave  (input rx_data, rx_fe, rx_pe, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: reloads from comp (0 acts as 1) at each wrap,
// emits a one-clock tick on terminal count, and restarts on a sync clear.
module uart_baud_tick #(
    parameter int COMP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COMP_W-1:0] comp_i,
    input  logic              clr_i,
    output logic              tick_o
);
    logic [COMP_W-1:0] cnt_q, cnt_d, reload;

    always_comb begin
        reload = (comp_i == '0) ? '0 : comp_i - COMP_W'(1);
        if (clr_i || cnt_q == '0) cnt_d = reload;
        else                      cnt_d = cnt_q - COMP_W'(1);
    end

    assign tick_o = !clr_i && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver with 16x oversampling and a one-entry holding register.
// state  | meaning
// IDLE   | waiting for a high-to-low transition on the synchronized line
// START  | qualifying the start bit; a high majority is a glitch
// DATA   | shifting in 8 bits, LSB first
// PARITY | checking the optional parity bit
// STOP   | sampling the stop bit and pushing the byte
module uart_rx_core #(
    parameter int COMP_W = 16,
    parameter int OVS    = uart_pkg::OVS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en_i,
    input  logic [COMP_W-1:0] comp_i,
    input  logic              par_en_i,
    input  logic              par_odd_i,
    input  logic              uart_rx_i,
    input  logic              err_clr_i,
    output logic              rx_ovf_o,
    output logic              busy_o,
    uart_rx_core_if.master    rx_if
);
    import uart_pkg::*;

    localparam int SCNT_W = $clog2(OVS);

    rx_state_t         state_q, state_d;
    logic              meta_q, rxs_q, prev_hi_q;
    logic [1:0]        vld_q;
    logic [SCNT_W-1:0] scnt_q;
    logic [2:0]        bit_q;
    logic              s7_q, s8_q, pe_q;
    logic [7:0]        shift_q;
    rx_hold_t          hold_q, hold_d;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic              tick, start_det, at_dec, at_end, maj, push;

    uart_baud_tick #(.COMP_W(COMP_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .comp_i (comp_i),
        .clr_i  (start_det),
        .tick_o (tick)
    );

    // vld_q marks when rxs_q carries a real line sample rather than its reset value,
    // so a line held low through reset is not taken as a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= 1'b1;
            rxs_q     <= 1'b1;
            vld_q     <= '0;
            prev_hi_q <= 1'b0;
        end else begin
            meta_q    <= uart_rx_i;
            rxs_q     <= meta_q;
            vld_q     <= {vld_q[0], 1'b1};
            prev_hi_q <= vld_q[1] & rxs_q;
        end
    end

    assign at_dec = tick && (scnt_q == SCNT_W'(SMP_C));
    assign at_end = tick && (scnt_q == SCNT_W'(SMP_END));
    assign maj    = maj3(s7_q, s8_q, rxs_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!rx_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_det) state_d = START;
                START:   if (at_dec && maj) state_d = IDLE;
                         else if (at_end) state_d = DATA;
                DATA:    if (at_end && bit_q == 3'd7) state_d = par_en_i ? PARITY : STOP;
                PARITY:  if (at_end) state_d = STOP;
                STOP:    if (at_dec) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        start_det = (state_q == IDLE) && rx_en_i && prev_hi_q && !rxs_q;
        push      = (state_q == STOP) && rx_en_i && at_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt_q  <= '0;
            bit_q   <= '0;
            s7_q    <= 1'b1;
            s8_q    <= 1'b1;
            shift_q <= '0;
            pe_q    <= 1'b0;
        end else begin
            if (start_det) begin
                scnt_q <= '0;
                bit_q  <= '0;
                pe_q   <= 1'b0;
            end else if (tick) begin
                scnt_q <= scnt_q + SCNT_W'(1);
            end
            if (tick && scnt_q == SCNT_W'(SMP_A)) s7_q <= rxs_q;
            if (tick && scnt_q == SCNT_W'(SMP_B)) s8_q <= rxs_q;
            if (state_q == DATA && at_dec) shift_q <= {maj, shift_q[7:1]};
            if (state_q == DATA && at_end) bit_q <= bit_q + 3'd1;
            if (state_q == PARITY && at_dec) pe_q <= ((^shift_q) ^ maj) != par_odd_i;
        end
    end

    // Overrun set beats a simultaneous err_clr.
    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (err_clr_i) ovf_d = 1'b0;
        if (push) begin
            if (!valid_q || rx_if.rx_ready) begin
                hold_d  = '{data: shift_q, fe: !maj, pe: pe_q};
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rx_if.rx_data  = hold_q.data;
    assign rx_if.rx_fe    = hold_q.fe;
    assign rx_if.rx_pe    = hold_q.pe;
    assign rx_if.rx_valid = valid_q;
    assign rx_ovf_o       = ovf_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames built from byte values,
// expected byte/flags computed from frame rules.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int COMP_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_en, par_en, par_odd, uart_rx, err_clr;
    logic [COMP_W-1:0] comp;
    logic              rx_ovf, busy;
    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                fall_q[$];

    uart_rx_core_if rx_if ();

    uart_rx_core #(.COMP_W(COMP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en_i   (rx_en),
        .comp_i    (comp),
        .par_en_i  (par_en),
        .par_odd_i (par_odd),
        .uart_rx_i (uart_rx),
        .err_clr_i (err_clr),
        .rx_ovf_o  (rx_ovf),
        .busy_o    (busy),
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int bit_clks();
        return 16 * ((comp == '0) ? 1 : int'(comp));
    endfunction

    // Parity bit that makes the frame correct for the current par_odd setting.
    function automatic logic good_par(input logic [7:0] d);
        int ones = $countones(d);
        return par_odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    function automatic logic model_pe(input logic [7:0] d, input logic p);
        int total = $countones(d) + int'(p);
        if (!par_en) return 1'b0;
        return ((total % 2) == 1) != par_odd;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int gap_bits);
        int bc = bit_clks();
        @(negedge clk);
        uart_rx = 1'b0;
        fall_q.push_back(cyc);
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (bc) @(negedge clk);
        end
        if (par_en) begin
            uart_rx = p;
            repeat (bc) @(negedge clk);
        end
        uart_rx = stop;
        repeat (bc) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap_bits * bc) @(negedge clk);
    endtask

    task automatic pop_byte();
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_if.rx_valid); end
        n_checks++; if (rx_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_if.rx_data); end
        n_checks++; if ({rx_if.rx_fe, rx_if.rx_pe} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {rx_if.rx_fe, rx_if.rx_pe}); end
        n_checks++; if ({rx_ovf, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_busy: got %b want 00", {rx_ovf, busy}); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if ({rx_if.rx_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00", {rx_if.rx_valid, busy}); end
    endtask

    task automatic test_basic();
        int lat = -1;
        comp = 16'd4;
        par_en = 1'b0;
        fall_q.delete();
        fork
            send_frame(8'hA5, 1'b0, 1'b1, 1);
            begin
                int k = 0;
                while (fall_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
                k = 0;
                while (rx_if.rx_valid !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
                if (rx_if.rx_valid === 1'b1 && fall_q.size() > 0) lat = cyc - fall_q[0];
            end
        join
        n_checks++; if (lat < 150 * 4 || lat > 158 * 4) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d..%0d", lat, 150 * 4, 158 * 4); end
        n_checks++; if (rx_if.rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", rx_if.rx_data); end
        n_checks++; if ({rx_if.rx_fe, rx_if.rx_pe} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {rx_if.rx_fe, rx_if.rx_pe}); end
        pop_byte();
        n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid: got %b want 0", rx_if.rx_valid); end
        n_checks++; if (rx_if.rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_pop_data_kept: got %h want a5", rx_if.rx_data); end
    endtask

    task automatic test_glitch();
        logic busy_seen = 1'b0;
        logic valid_seen = 1'b0;
        int   k = 0;
        comp = 16'd4;
        @(negedge clk);
        uart_rx = 1'b0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); busy_seen |= busy; end
        uart_rx = 1'b1;
        while (k < 40 && busy !== 1'b0) begin @(negedge clk); busy_seen |= busy; k++; end
        n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_return: got %b want 0 within 40 clk", busy); end
        for (int i = 0; i < 300; i++) begin @(negedge clk); valid_seen |= rx_if.rx_valid; end
        n_checks++; if (valid_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_no_byte: got %b want 0", valid_seen); end
    endtask

    task automatic test_framing();
        comp = 16'd4;
        par_en = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 2);
        n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL fe_valid: got %b want 1", rx_if.rx_valid); end
        n_checks++; if (rx_if.rx_data !== 8'h3C) begin n_fail++; $display("FAIL fe_data: got %h want 3c", rx_if.rx_data); end
        n_checks++; if (rx_if.rx_fe !== 1'b1) begin n_fail++; $display("FAIL fe_flag: got %b want 1", rx_if.rx_fe); end
        pop_byte();
        send_frame(8'h81, 1'b0, 1'b1, 1);
        n_checks++; if (rx_if.rx_data !== 8'h81) begin n_fail++; $display("FAIL fe_next_data: got %h want 81", rx_if.rx_data); end
        n_checks++; if ({rx_if.rx_valid, rx_if.rx_fe} !== 2'b10) begin n_fail++; $display("FAIL fe_next_flags: got %b want 10", {rx_if.rx_valid, rx_if.rx_fe}); end
        pop_byte();
    endtask

    task automatic test_parity();
        comp = 16'd4;
        par_en = 1'b1;
        par_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, 1);
        n_checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'h07}) begin n_fail++; $display("FAIL par_bad_data: got %b/%h want 1/07", rx_if.rx_valid, rx_if.rx_data); end
        n_checks++; if (rx_if.rx_pe !== 1'b1) begin n_fail++; $display("FAIL par_bad_pe: got %b want 1", rx_if.rx_pe); end
        pop_byte();
        send_frame(8'h07, 1'b0, 1'b1, 1);
        n_checks++; if ({rx_if.rx_valid, rx_if.rx_pe, rx_if.rx_fe} !== 3'b100) begin n_fail++; $display("FAIL par_good: got %b want 100", {rx_if.rx_valid, rx_if.rx_pe, rx_if.rx_fe}); end
        pop_byte();
        par_en = 1'b0;
        par_odd = 1'b0;
    endtask

    task automatic test_overrun();
        comp = 16'd4;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        send_frame(8'h22, 1'b0, 1'b1, 1);
        n_checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL ovf_held: got %b/%h want 1/11", rx_if.rx_valid, rx_if.rx_data); end
        n_checks++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", rx_ovf); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", rx_ovf); end
        pop_byte();
    endtask

    task automatic test_ready_on_push();
        comp = 16'd4;
        fall_q.delete();
        fork
            begin
                send_frame(8'h11, 1'b0, 1'b1, 0);
                send_frame(8'h22, 1'b0, 1'b1, 1);
            end
            begin
                int k = 0;
                int d = 0;
                while (fall_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
                k = 0;
                while (rx_if.rx_valid !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
                if (fall_q.size() > 0) d = cyc - fall_q[0];
                k = 0;
                while (fall_q.size() < 2 && k < 2000) begin @(negedge clk); k++; end
                if (fall_q.size() >= 2) begin
                    while (cyc < fall_q[1] + d - 1) @(negedge clk);
                    rx_if.rx_ready = 1'b1;
                    @(negedge clk);
                    rx_if.rx_ready = 1'b0;
                end
            end
        join
        n_checks++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'h22}) begin n_fail++; $display("FAIL push_pop_data: got %b/%h want 1/22", rx_if.rx_valid, rx_if.rx_data); end
        n_checks++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL push_pop_ovf: got %b want 0", rx_ovf); end
        pop_byte();
    endtask

    task automatic test_disable();
        logic done = 1'b0;
        logic valid_seen = 1'b0;
        comp = 16'd4;
        fall_q.delete();
        fork
            begin send_frame(8'h3C, 1'b0, 1'b1, 1); done = 1'b1; end
            begin
                int k = 0;
                while (fall_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
                while (fall_q.size() > 0 && cyc < fall_q[0] + 3 * 64) @(negedge clk);
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dis_busy_before: got %b want 1", busy); end
                rx_en = 1'b0;
                @(negedge clk);
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy_after: got %b want 0", busy); end
                while (!done) begin @(negedge clk); valid_seen |= rx_if.rx_valid; end
            end
        join
        rx_en = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++; if ((valid_seen | rx_if.rx_valid) !== 1'b0) begin n_fail++; $display("FAIL dis_dropped: got %b want 0", valid_seen); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, stop, exp_fe, exp_pe;
        for (int n = 0; n < 10; n++) begin
            comp    = COMP_W'($urandom_range(0, 5));
            par_en  = 1'($urandom_range(0, 1));
            par_odd = 1'($urandom_range(0, 1));
            d       = 8'($urandom);
            p       = good_par(d) ^ ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 4) != 0);
            exp_fe  = !stop;
            exp_pe  = model_pe(d, p);
            send_frame(d, p, stop, 2);
            n_checks++;
            if ({rx_if.rx_valid, rx_if.rx_data, rx_if.rx_fe, rx_if.rx_pe} !== {1'b1, d, exp_fe, exp_pe}) begin
                n_fail++;
                $display("FAIL rand_%0d: got v=%b d=%h fe=%b pe=%b want v=1 d=%h fe=%b pe=%b (comp=%0d par_en=%b odd=%b)",
                         n, rx_if.rx_valid, rx_if.rx_data, rx_if.rx_fe, rx_if.rx_pe, d, exp_fe, exp_pe, comp, par_en, par_odd);
            end
            pop_byte();
        end
        par_en = 1'b0;
        par_odd = 1'b0;
    endtask

    task automatic test_reset_mid();
        comp = 16'd4;
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        send_frame(8'h96, 1'b0, 1'b1, 1);
        n_checks++; if ({rx_if.rx_valid, rx_ovf} !== 2'b11) begin n_fail++; $display("FAIL rmid_pre: got %b want 11", {rx_if.rx_valid, rx_ovf}); end
        fall_q.delete();
        fork
            send_frame(8'h5A, 1'b0, 1'b1, 1);
            begin
                int k = 0;
                while (fall_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
                while (fall_q.size() > 0 && cyc < fall_q[0] + 4 * 64 + 32) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                n_checks++; if ({rx_if.rx_valid, rx_ovf, busy} !== 3'b000) begin n_fail++; $display("FAIL rmid_ctrl: got %b want 000", {rx_if.rx_valid, rx_ovf, busy}); end
                n_checks++; if ({rx_if.rx_data, rx_if.rx_fe, rx_if.rx_pe} !== 10'h000) begin n_fail++; $display("FAIL rmid_data: got %h want 000", {rx_if.rx_data, rx_if.rx_fe, rx_if.rx_pe}); end
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        n_checks++; if ({rx_if.rx_valid, rx_if.rx_data, rx_if.rx_fe, rx_if.rx_pe} !== {1'b1, 8'h5A, 2'b00}) begin
            n_fail++; $display("FAIL rmid_after: got v=%b d=%h fe=%b pe=%b want v=1 d=5a fe=0 pe=0", rx_if.rx_valid, rx_if.rx_data, rx_if.rx_fe, rx_if.rx_pe);
        end
        pop_byte();
    endtask

    initial begin
        rx_en          = 1'b1;
        comp           = 16'd4;
        par_en         = 1'b0;
        par_odd        = 1'b0;
        uart_rx        = 1'b1;
        err_clr        = 1'b0;
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_overrun();
        test_ready_on_push();
        test_disable();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
